// File: rtl/jtframe_video_pkg.sv
// Shared video definitions for the jtframe video blocks.
//   VCNTW      : width of the horizontal/vertical position counters.
//   PAT_*      : test-pattern select codes driven on the pattern input.
package jtframe_video_pkg;
  localparam int VCNTW = 9;

  localparam logic [1:0] PAT_BLACK = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRID  = 2'd2;
  localparam logic [1:0] PAT_RAMP  = 2'd3;
endpackage

// File: rtl/jtframe_vidgen_if.sv
// Video bus as consumed by the scaler and other video filters.
//   master : driven by a video source (hcnt/vcnt/frame, HS/VS/HB/VB, RGB).
//   slave  : the consuming filter.
interface jtframe_vidgen_if #(
  parameter int COLORW = 4
);
  import jtframe_video_pkg::*;

  logic [VCNTW-1:0]  hcnt;
  logic [VCNTW-1:0]  vcnt;
  logic [7:0]        frame;
  logic              HS;
  logic              VS;
  logic              HB;
  logic              VB;
  logic [COLORW-1:0] red;
  logic [COLORW-1:0] green;
  logic [COLORW-1:0] blue;

  modport master (output hcnt, vcnt, frame, HS, VS, HB, VB, red, green, blue);
  modport slave  (input  hcnt, vcnt, frame, HS, VS, HB, VB, red, green, blue);
endinterface

// File: rtl/jtframe_vidgen_cnt.sv
// Wrapping counter 0..MAX with enable and terminal-count flag.
//   clk, rst : clock, asynchronous active-high reset
//   i_en     : count enable
//   o_cnt    : current count
//   o_tc     : high while o_cnt == MAX (next enabled edge wraps to 0)
module jtframe_vidgen_cnt #(
  parameter int W   = 9,
  parameter int MAX = 383
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  assign o_tc = (o_cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_cnt <= '0;
    else if (i_en) o_cnt <= o_tc ? '0 : o_cnt + 1'b1;
  end
endmodule

// File: rtl/jtframe_vidgen.sv
// Programmable video timing generator and test-pattern source.
//   clk, rst : clock, asynchronous active-high reset
//   pxl_cen  : pixel clock enable; all state advances only when high
//   pattern  : 0 black, 1 colour bars, 2 grid, 3 scrolling ramp
//              (sampled at frame start only)
//   vid      : video bus master (counters, frame, syncs, blanks, RGB)
// Syncs, blanks and RGB are registered and lag hcnt/vcnt by one pxl_cen.
module jtframe_vidgen
  import jtframe_video_pkg::*;
#(
  parameter int COLORW   = 4,
  parameter int HTOTAL   = 384,
  parameter int HACTIVE  = 256,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 262,
  parameter int VACTIVE  = 224,
  parameter int VS_START = 234,
  parameter int VS_LEN   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pxl_cen,
  input  logic [1:0]           pattern,
  jtframe_vidgen_if.master     vid
);
  localparam int BARW = HACTIVE / 8;
  localparam logic [VCNTW:0] HS_END = (VCNTW+1)'(HS_START + HS_LEN);
  localparam logic [VCNTW:0] VS_END = (VCNTW+1)'(VS_START + VS_LEN);

  if (!(HACTIVE < HTOTAL && VACTIVE < VTOTAL)) begin : g_bad_active
    $error("jtframe_vidgen: active area must be smaller than total");
  end
  if (!(HS_START + HS_LEN <= HTOTAL && VS_START + VS_LEN <= VTOTAL)) begin : g_bad_sync
    $error("jtframe_vidgen: sync pulse extends past the total count");
  end
  if (HACTIVE % 8 != 0) begin : g_bad_hact
    $error("jtframe_vidgen: HACTIVE must be a multiple of 8");
  end

  logic [VCNTW-1:0]  w_hcnt, w_vcnt;
  logic              w_htc, w_vtc, w_ven, w_fstart;
  logic              w_hb, w_vb, w_hs, w_vs;
  logic [2:0]        w_bar;
  logic              w_grid;
  logic [7:0]        w_ramp_sum;
  logic [COLORW-1:0] w_ramp;
  logic [COLORW-1:0] w_red, w_green, w_blue;

  logic [7:0]        r_frame;
  logic [1:0]        r_pat;
  logic              r_hs, r_vs, r_hb, r_vb;
  logic [COLORW-1:0] r_red, r_green, r_blue;

  assign w_ven    = pxl_cen & w_htc;
  assign w_fstart = w_ven & w_vtc;

  jtframe_vidgen_cnt #(.W(VCNTW), .MAX(HTOTAL-1)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (pxl_cen),
    .o_cnt (w_hcnt),
    .o_tc  (w_htc)
  );

  jtframe_vidgen_cnt #(.W(VCNTW), .MAX(VTOTAL-1)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_ven),
    .o_cnt (w_vcnt),
    .o_tc  (w_vtc)
  );

  // Timing decode of the pixel currently addressed by the counters.
  // vcnt only moves on the hcnt wrap, so VS naturally changes at line start.
  assign w_hb = (w_hcnt >= VCNTW'(HACTIVE));
  assign w_vb = (w_vcnt >= VCNTW'(VACTIVE));
  assign w_hs = (w_hcnt >= VCNTW'(HS_START)) && ({1'b0, w_hcnt} < HS_END);
  assign w_vs = (w_vcnt >= VCNTW'(VS_START)) && ({1'b0, w_vcnt} < VS_END);

  // Bar index by comparison against bar boundaries (avoids a divider).
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_hcnt >= VCNTW'(k * BARW)) w_bar = 3'(k);
    end
  end

  assign w_grid = (w_hcnt[3:0] == 4'd0) || (w_vcnt[3:0] == 4'd0) ||
                  (w_hcnt == VCNTW'(HACTIVE-1)) || (w_vcnt == VCNTW'(VACTIVE-1));

  // Ramp keeps the top COLORW bits of an 8-bit wrapping sum.
  assign w_ramp_sum = w_hcnt[7:0] + r_frame;
  assign w_ramp     = COLORW'(w_ramp_sum >> (8 - COLORW));

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (r_pat)
      PAT_BARS: begin
        w_red   = {COLORW{w_bar[1]}};
        w_green = {COLORW{w_bar[2]}};
        w_blue  = {COLORW{w_bar[0]}};
      end
      PAT_GRID: begin
        w_red   = {COLORW{w_grid}};
        w_green = {COLORW{w_grid}};
        w_blue  = {COLORW{w_grid}};
      end
      PAT_RAMP: begin
        w_red   = w_ramp;
        w_green = w_ramp;
        w_blue  = w_ramp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
      r_pat   <= PAT_BLACK;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_hb    <= 1'b1;
      r_vb    <= 1'b1;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (pxl_cen) begin
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_hb <= w_hb;
      r_vb <= w_vb;
      // Colour shares the blanking stage so both stay aligned.
      r_red   <= (w_hb || w_vb) ? '0 : w_red;
      r_green <= (w_hb || w_vb) ? '0 : w_green;
      r_blue  <= (w_hb || w_vb) ? '0 : w_blue;
      if (w_fstart) begin
        r_frame <= r_frame + 8'd1;
        r_pat   <= pattern;
      end
    end
  end

  assign vid.hcnt  = w_hcnt;
  assign vid.vcnt  = w_vcnt;
  assign vid.frame = r_frame;
  assign vid.HS    = r_hs;
  assign vid.VS    = r_vs;
  assign vid.HB    = r_hb;
  assign vid.VB    = r_vb;
  assign vid.red   = r_red;
  assign vid.green = r_green;
  assign vid.blue  = r_blue;
endmodule

// File: tb/tb_jtframe_vidgen.sv
// Directed bench for jtframe_vidgen. Horizontal timing uses the default
// values; the frame is shortened vertically (22 lines) so several frames fit
// in a short run.
module tb_jtframe_vidgen;
  localparam int HT = 384;
  localparam int VT = 22;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       slow = 1'b1;
  int         pos = 0;
  int         nvec = 0;
  int         nerr = 0;

  jtframe_vidgen_if #(.COLORW(4)) vid ();

  jtframe_vidgen #(
    .COLORW(4), .HTOTAL(HT), .HACTIVE(256), .HS_START(288), .HS_LEN(32),
    .VTOTAL(VT), .VACTIVE(18), .VS_START(18), .VS_LEN(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .pattern (pattern),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n pixel enables; returns on a falling edge with pxl_cen low.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      pxl_cen = 1'b1;
      @(negedge clk);
      if (slow) begin
        pxl_cen = 1'b0;
        @(negedge clk);
      end
    end
    pxl_cen = 1'b0;
    pos += n;
  endtask

  task automatic goto(input int f, input int v, input int h);
    int t;
    t = f * FR + v * HT + h;
    if (t < pos) begin
      $display("FAIL goto: observed position %0d, expected at most %0d", pos, t);
      $fatal(1);
    end
    adv(t - pos);
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, vid.red, vid.green, vid.blue};
  endfunction

  logic [11:0] bars [8] = '{12'h000, 12'h00F, 12'hF00, 12'hF0F,
                            12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hcnt", vid.hcnt, 0);
    chk("rst_vcnt", vid.vcnt, 0);
    chk("rst_frame", vid.frame, 0);
    chk("rst_HS", vid.HS, 0);
    chk("rst_VS", vid.VS, 0);
    chk("rst_HB", vid.HB, 1);
    chk("rst_VB", vid.VB, 1);
    chk("rst_rgb", rgb(), 0);
    rst = 1'b0;

    // Hold while pxl_cen is low
    repeat (3) @(negedge clk);
    chk("hold_hcnt", vid.hcnt, 0);

    // First line, pxl_cen every second clock
    adv(1);
    chk("first_hcnt", vid.hcnt, 1);
    chk("first_HB", vid.HB, 0);
    chk("first_VB", vid.VB, 0);
    chk("first_HS", vid.HS, 0);
    goto(0, 0, 256); chk("hb_before", vid.HB, 0);
    adv(1);          chk("hb_rise", vid.HB, 1);
    goto(0, 0, 288); chk("hs_before", vid.HS, 0);
    adv(1);          chk("hs_rise", vid.HS, 1);
    goto(0, 0, 320); chk("hs_last", vid.HS, 1);
    adv(1);          chk("hs_fall", vid.HS, 0);
    goto(0, 0, 383); chk("eol_vcnt", vid.vcnt, 0);
    adv(1);
    chk("wrap_hcnt", vid.hcnt, 0);
    chk("wrap_vcnt", vid.vcnt, 1);
    chk("wrap_HB", vid.HB, 1);
    adv(1);          chk("hb_fall", vid.HB, 0);

    // Vertical timing, pxl_cen every clock from here on
    slow = 1'b0;
    goto(0, 18, 0);  chk("vb_before", vid.VB, 0);
                     chk("vs_before", vid.VS, 0);
    adv(1);          chk("vb_rise", vid.VB, 1);
                     chk("vs_rise", vid.VS, 1);
    goto(0, 20, 200); chk("vs_mid", vid.VS, 1);
    goto(0, 21, 0);  chk("vs_last", vid.VS, 1);
    adv(1);          chk("vs_fall", vid.VS, 0);
    pattern = 2'd1;
    goto(0, 21, 383); chk("frame_before", vid.frame, 0);
    adv(1);
    chk("frame_inc", vid.frame, 1);
    chk("frame_vcnt", vid.vcnt, 0);
    chk("frame_rgb_blank", rgb(), 0);

    // Colour bars on line 0 of frame 1
    for (int k = 0; k < 8; k++) begin
      goto(1, 0, 32 * k + 1);
      chk($sformatf("bar%0d", k), rgb(), {20'd0, bars[k]});
    end
    goto(1, 0, 256); chk("bar_last_px", rgb(), 12'hFFF);
    goto(1, 0, 300); chk("bar_hblank", rgb(), 0);
    pattern = 2'd0;
    goto(1, 5, 225); chk("bar_midframe_hold", rgb(), 12'hFFF);

    // Frame 2 latched black; a switch to grid mid-frame has no effect
    goto(2, 10, 0);
    pattern = 2'd2;
    goto(2, 16, 1);  chk("grid_late_v16", rgb(), 0);
    goto(2, 17, 101); chk("grid_late_v17", rgb(), 0);

    // Frame 3 shows the grid
    goto(3, 0, 1);   chk("grid_v0_h0", rgb(), 12'hFFF);
    goto(3, 1, 17);  chk("grid_h16", rgb(), 12'hFFF);
    goto(3, 1, 18);  chk("grid_h17", rgb(), 12'h000);
    goto(3, 1, 241); chk("grid_h240", rgb(), 12'hFFF);
    goto(3, 1, 255); chk("grid_h254", rgb(), 12'h000);
    goto(3, 1, 256); chk("grid_h255", rgb(), 12'hFFF);
    goto(3, 5, 6);   chk("grid_v5_h5", rgb(), 12'h000);
    goto(3, 16, 6);  chk("grid_v16", rgb(), 12'hFFF);
    goto(3, 17, 6);  chk("grid_v17", rgb(), 12'hFFF);
    goto(3, 18, 1);  chk("grid_vblank", rgb(), 12'h000);
    pattern = 2'd3;

    // Scrolling ramp
    goto(4, 2, 13);  chk("ramp_f4_h12", rgb(), 12'h111);
    goto(5, 0, 11);
    chk("ramp_frame", vid.frame, 5);
    chk("ramp_h10", rgb(), 12'h000);
    goto(5, 0, 100); chk("ramp_h99", rgb(), 12'h666);
    goto(5, 0, 201); chk("ramp_h200", rgb(), 12'hCCC);
    goto(5, 0, 251); chk("ramp_h250", rgb(), 12'hFFF);
    goto(5, 0, 252); chk("ramp_h251", rgb(), 12'h000);

    // Asynchronous reset mid-frame
    goto(5, 10, 100);
    chk("pre_rst_hcnt", vid.hcnt, 100);
    chk("pre_rst_vcnt", vid.vcnt, 10);
    #2 rst = 1'b1;
    #1;
    chk("arst_hcnt", vid.hcnt, 0);
    chk("arst_vcnt", vid.vcnt, 0);
    chk("arst_frame", vid.frame, 0);
    chk("arst_HS", vid.HS, 0);
    chk("arst_VS", vid.VS, 0);
    chk("arst_HB", vid.HB, 1);
    chk("arst_VB", vid.VB, 1);
    chk("arst_rgb", rgb(), 0);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
    adv(1);
    chk("post_rst_hcnt", vid.hcnt, 1);
    chk("post_rst_frame", vid.frame, 0);
    chk("post_rst_HB", vid.HB, 0);
    chk("post_rst_rgb", rgb(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
